// File: rtl/regfile_write_arbiter.sv
// regfile_write_arbiter: two-requester write-port arbiter with lock/burst support and a registered write stage
module regfile_write_arbiter #(
    parameter int MAX_BURST = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        a_valid,
    input  logic [1:0]  a_reg,
    input  logic [15:0] a_data,
    input  logic        a_lock,
    output logic        a_ready,
    input  logic        b_valid,
    input  logic [1:0]  b_reg,
    input  logic [15:0] b_data,
    input  logic        b_lock,
    output logic        b_ready,
    output logic        rf_write,
    output logic [1:0]  rf_reg,
    output logic [15:0] rf_write_data,
    output logic        locked
);
    localparam logic [1:0] S_OPEN   = 2'd0;
    localparam logic [1:0] S_LOCK_A = 2'd1;
    localparam logic [1:0] S_LOCK_B = 2'd2;
    localparam logic [2:0] BURST_MAX = 3'(MAX_BURST);
    localparam logic       CAN_LOCK  = MAX_BURST > 1;

    logic [1:0]  state_q, state_d;
    logic        pri_q, pri_d;
    logic [2:0]  bcnt_q, bcnt_d;
    logic        wr_q;
    logic [1:0]  reg_q;
    logic [15:0] data_q;
    logic        acc, acc_lock;
    logic [2:0]  bcnt_inc;

    // pri_q=0 favours A, pri_q=1 favours B; a lock shuts the other requester out entirely
    assign a_ready  = !reset && a_valid && (state_q == S_LOCK_A || (state_q == S_OPEN && (!b_valid || !pri_q)));
    assign b_ready  = !reset && b_valid && (state_q == S_LOCK_B || (state_q == S_OPEN && (!a_valid || pri_q)));
    assign acc      = a_ready || b_ready;
    assign acc_lock = a_ready ? a_lock : b_lock;
    assign bcnt_inc = bcnt_q + 3'd1;
    assign locked   = state_q != S_OPEN;
    assign rf_write      = wr_q;
    assign rf_reg        = reg_q;
    assign rf_write_data = data_q;

    // Next-state logic: in a lock, a cycle with no accept means the holder dropped valid
    always_comb begin
        state_d = state_q;
        bcnt_d  = bcnt_q;
        pri_d   = a_ready ? 1'b1 : b_ready ? 1'b0 : pri_q;
        if (state_q == S_OPEN) begin
            state_d = (acc && acc_lock && CAN_LOCK) ? (a_ready ? S_LOCK_A : S_LOCK_B) : S_OPEN;
            bcnt_d  = (acc && acc_lock && CAN_LOCK) ? 3'd1 : 3'd0;
        end else if (!acc || !acc_lock || bcnt_inc == BURST_MAX) begin
            state_d = S_OPEN;
            bcnt_d  = 3'd0;
        end else begin
            bcnt_d  = bcnt_inc;
        end
    end

    // Arbitration state
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_OPEN;
            pri_q   <= 1'b0;
            bcnt_q  <= 3'd0;
        end else begin
            state_q <= state_d;
            pri_q   <= pri_d;
            bcnt_q  <= bcnt_d;
        end
    end

    // Registered write stage: address/data hold their last values between writes
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_q   <= 1'b0;
            reg_q  <= 2'd0;
            data_q <= 16'h0000;
        end else begin
            wr_q <= acc;
            if (acc) begin
                reg_q  <= a_ready ? a_reg : b_reg;
                data_q <= a_ready ? a_data : b_data;
            end
        end
    end
endmodule

// File: doc/regfile_write_arbiter.md
REGFILE_WRITE_ARBITER -- requirements
Module: regfile_write_arbiter

Interface
REQ-001 Parameter: MAX_BURST, default 4, maximum consecutive accepts a locked requester may hold; legal range 1..7.
REQ-002 Port: clk  input  1  single clock; all state updates on rising edge.
REQ-003 Port: reset  input  1  asynchronous, active-high reset.
REQ-004 Port: a_valid  input  1  requester A has a write pending.
REQ-005 Port: a_reg  input  2  requester A destination register index.
REQ-006 Port: a_data  input  16  requester A write data.
REQ-007 Port: a_lock  input  1  requester A asks to keep the port after this accept.
REQ-008 Port: a_ready  output  1  requester A write accepted this cycle when a_valid also high.
REQ-009 Ports: b_valid, b_reg, b_data, b_lock, b_ready  same directions/widths/meanings as REQ-004..REQ-008, for requester B.
REQ-010 Port: rf_write  output  1  write strobe to the 4x16 register file.
REQ-011 Port: rf_reg  output  2  register index driven to the register file address port.
REQ-012 Port: rf_write_data  output  16  write data to the register file.
REQ-013 Port: locked  output  1  high while the FSM is in LOCK_A or LOCK_B.

Function
REQ-014 Accept of X = x_valid & x_ready at a rising clk edge; at most one of a_ready/b_ready is high in any cycle.
REQ-015 x_ready is combinational from current state and x_valid, and is never high while x_valid is low or while reset is high.
REQ-016 FSM states: OPEN, LOCK_A, LOCK_B; a 1-bit round-robin pointer pri (A or B) and a 3-bit burst counter bcnt.
REQ-017 In OPEN: if only one requester is valid it gets ready; if both are valid, the requester selected by pri gets ready.
REQ-018 In LOCK_X: only X may be granted; the other requester's ready stays low regardless of its valid.
REQ-019 After every accept from X, pri points to the other requester.
REQ-020 Write stage is registered: an accept at edge N drives rf_write=1, rf_reg=x_reg, rf_write_data=x_data during cycle N+1; latency exactly one cycle; throughput one write per cycle.
REQ-021 In a cycle following no accept, rf_write=0 and rf_reg/rf_write_data hold their last values.
REQ-022 OPEN -> LOCK_X on an accept from X with x_lock=1 when MAX_BURST>1; bcnt set to 1. With MAX_BURST=1 the FSM stays OPEN.
REQ-023 In LOCK_X, each accept from X increments bcnt.
REQ-024 LOCK_X -> OPEN when X is accepted with x_lock=0, or when that accept makes bcnt equal MAX_BURST (forced rotation), or when x_valid is low for a cycle (lock released, no accept that cycle).
REQ-025 On entry to OPEN, bcnt clears to 0; pri follows REQ-019, so after forced rotation a pending other requester wins the next OPEN cycle.
REQ-026 x_reg/x_data/x_lock are sampled only at the accepting edge; changes while x_ready is low have no effect.

Reset
REQ-027 While reset is high: rf_write=0, rf_reg=0, rf_write_data=0x0000, locked=0, a_ready=b_ready=0, FSM=OPEN, pri=A, bcnt=0.
REQ-028 Reset asserted mid-lock or mid-write aborts the pending write (no rf_write pulse after reset deasserts without a new accept).
REQ-029 First cycle after reset release behaves as OPEN with pri=A.

Verification
REQ-030 Single write: a_valid=1, a_reg=2, a_data=0x1234 for one cycle -> a_ready=1 that cycle; next cycle rf_write=1, rf_reg=2, rf_write_data=0x1234; following cycle rf_write=0.
REQ-031 Contention: after reset, a_valid=b_valid=1 continuously, locks low -> accepts alternate A,B,A,B; rf_reg follows a_reg/b_reg in that order, one write per cycle.
REQ-032 Forced rotation: MAX_BURST=4, a_lock=1, a_valid=b_valid=1 continuously -> four consecutive A accepts with locked=1 from cycle after first accept, then locked=0 and B accepted next.
REQ-033 Early unlock/release: A locked, a_lock=0 on 2nd accept -> B accepted next cycle; separately, A locked and a_valid drops -> locked=0 and B ready the following cycle.
REQ-034 Reset mid-lock: in LOCK_A with bcnt=2, pulse reset -> all outputs per REQ-027, no rf_write after release, first contested cycle grants A.
